// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_sequencer
//  Purpose  : Control FSM for a 4-bit datapath. Accepts one instruction per
//             valid/ready handshake and sequences register reads, operand
//             latch, ALU execute and register write-back, pulsing done in
//             the write-back cycle.
//  Options  : DATAPATH_CARRY_CHAIN_EN - when defined, the stored carry is fed
//             to the ALU carry-in during EXEC so multi-word add/sub chains
//             work. When undefined, carry-in is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module datapath_sequencer #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_instr_valid,
  output logic          o_instr_ready,
  input  logic [11:0]   i_instr,
  output logic [AW-1:0] o_rf_addr,
  output logic          o_rf_we,
  output logic [DW-1:0] o_rf_wdata,
  input  logic [DW-1:0] i_rf_rdata,
  output logic [DW-1:0] o_alu_a,
  output logic [DW-1:0] o_alu_b,
  output logic [2:0]    o_alu_sel,
  output logic          o_alu_cin,
  input  logic [DW-1:0] i_alu_result,
  input  logic          i_alu_cout,
  output logic          o_carry_flag,
  output logic          o_done,
  output logic          o_busy
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_B  = 3'd2;
  localparam logic [2:0] S_LAT_B = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;

  // --------------------------------------------------------------------------
  // Opcodes (only the ones the sequencer itself must recognise)
  // --------------------------------------------------------------------------
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b110;

  // Instruction field positions
  localparam int C_OP_LSB  = 9;
  localparam int C_DST_LSB = 7;
  localparam int C_SRC_LSB = 5;
  localparam int C_IMM_LSB = 0;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]    r_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_src;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [2:0]    r_alu_sel;
  logic [DW-1:0] r_result;
  logic          r_carry;

  // --------------------------------------------------------------------------
  // Wires
  // --------------------------------------------------------------------------
  logic [2:0]    w_state_nxt;
  logic          w_accept;
  logic [2:0]    w_in_op;
  logic          w_op_is_arith;
  logic          w_unused;

  // Bit 4 of the instruction word carries no meaning.
  assign w_unused = &{1'b0, i_instr[4]};

  assign w_in_op       = i_instr[C_OP_LSB +: 3];
  assign w_accept      = i_instr_valid && (r_state == S_IDLE);
  assign w_op_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  // Next-state selection: LDI skips straight to write-back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_instr_valid) begin
          w_state_nxt = (w_in_op == OP_LDI) ? S_WB : S_RD_A;
        end
      end
      S_RD_A:  w_state_nxt = S_RD_B;
      S_RD_B:  w_state_nxt = S_LAT_B;
      S_LAT_B: w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset drops straight to IDLE, aborting any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction latch, loaded on the accepting edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_dst <= '0;
      r_src <= '0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= w_in_op;
      r_dst <= i_instr[C_DST_LSB +: AW];
      r_src <= i_instr[C_SRC_LSB +: AW];
      r_imm <= i_instr[C_IMM_LSB +: DW];
    end
  end

  // Operand capture: read data trails the address by one cycle, so the dst
  // value arrives during RD_B and the src value during LAT_B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else begin
      if (r_state == S_RD_B) begin
        r_alu_a <= i_rf_rdata;
      end
      if (r_state == S_LAT_B) begin
        r_alu_b   <= i_rf_rdata;
        r_alu_sel <= r_op;
      end
    end
  end

  // Result and carry capture at the end of EXEC; only ADD/SUB touch carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_result <= i_alu_result;
      if (w_op_is_arith) begin
        r_carry <= i_alu_cout;
      end
    end
  end

  // Register-file address: dst for the A read and write-back, src for the
  // B read, zero elsewhere.
  always_comb begin
    o_rf_addr = '0;
    case (r_state)
      S_RD_A:  o_rf_addr = r_dst;
      S_RD_B:  o_rf_addr = r_src;
      S_LAT_B: o_rf_addr = r_src;
      S_WB:    o_rf_addr = r_dst;
      default: o_rf_addr = '0;
    endcase
  end

  // Write-back path; the async reset forces IDLE, so a write can never be
  // presented while rst_n is low.
  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_wdata = '0;
    if (r_state == S_WB) begin
      o_rf_we    = 1'b1;
      o_rf_wdata = (r_op == OP_LDI) ? r_imm : r_result;
    end
  end

  assign o_done        = (r_state == S_WB);
  assign o_busy        = (r_state != S_IDLE);
  assign o_instr_ready = (r_state == S_IDLE);

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_sel     = r_alu_sel;
  assign o_carry_flag  = r_carry;

`ifdef DATAPATH_CARRY_CHAIN_EN
  // Chain the stored carry into the ALU only while it is executing.
  assign o_alu_cin = (r_state == S_EXEC) ? r_carry : 1'b0;
`else
  assign o_alu_cin = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_sequencer
//  Purpose  : Bench for datapath_sequencer with an external register file,
//             ALU and an instruction-level reference model feeding a
//             scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

  localparam int DW = 4;
  localparam int AW = 2;
`ifdef DATAPATH_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [11:0]   instr = '0;
  logic [AW-1:0] rf_addr;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_sel;
  logic          alu_cin;
  logic [DW-1:0] alu_result;
  logic          alu_cout;
  logic          carry_flag, done, busy;

  always #5 clk = ~clk;

  datapath_sequencer #(.DW(DW), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_instr(instr),
    .o_rf_addr(rf_addr), .o_rf_we(rf_we), .o_rf_wdata(rf_wdata), .i_rf_rdata(rf_rdata),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel), .o_alu_cin(alu_cin),
    .i_alu_result(alu_result), .i_alu_cout(alu_cout),
    .o_carry_flag(carry_flag), .o_done(done), .o_busy(busy)
  );

  // ALU definition: {carry_out, result}. SUB reports borrow as carry_out.
  function automatic logic [DW:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic cin);
    int s;
    int ia, ib, ic;
    ia = int'(a); ib = int'(b); ic = int'(cin);
    case (op)
      3'd0:    begin s = ia + ib + ic; return {(s > 15), DW'(s & 15)}; end
      3'd1:    begin s = ia - ib - ic; return {(s < 0), DW'(s & 15)}; end
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~(a ^ b)};
      3'd7:    return {1'b0, ~a};
      default: return '0;
    endcase
  endfunction

  // Environment ALU.
  always_comb begin
    {alu_cout, alu_result} = alu_f(alu_sel, alu_a, alu_b, alu_cin);
  end

  // Environment register file: registered read, read-before-write.
  logic          rf_clear = 1'b1;
  logic [DW-1:0] rf_mem [4];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
      rf_rdata <= '0;
    end else begin
      rf_rdata <= rf_mem[rf_addr];
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          carry;
    logic          is_alu;
    logic [DW-1:0] a, b;
    logic [2:0]    op;
    int            lat;
    int            acc_cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_regs [4] = '{default: '0};
  logic          m_carry = 1'b0;

  function automatic logic [11:0] mk(input int op, input int dst, input int src, input int imm);
    return {3'(op), 2'(dst), 2'(src), 1'b0, 4'(imm)};
  endfunction

  // Issue one instruction; called on a falling edge. With upd=0 the model
  // and scoreboard are left alone (used for the aborted instruction).
  task automatic issue(input logic [11:0] ins, input bit upd);
    exp_t e;
    logic [DW:0] r;
    int n = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!instr_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=ready_low expected=ready_high");
        instr_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (upd) begin
      e.op      = ins[11:9];
      e.addr    = ins[8:7];
      e.acc_cyc = cyc;
      e.a       = m_regs[ins[8:7]];
      e.b       = m_regs[ins[6:5]];
      if (e.op == 3'b110) begin
        e.data = ins[3:0]; e.lat = 1; e.is_alu = 1'b0;
      end else begin
        r = alu_f(e.op, e.a, e.b, CHAIN ? m_carry : 1'b0);
        e.data = r[DW-1:0]; e.lat = 5; e.is_alu = 1'b1;
        if (e.op == 3'b000 || e.op == 3'b001) m_carry = r[DW];
      end
      m_regs[e.addr] = e.data;
      e.carry = m_carry;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      chk("ready_not_busy", 32'(instr_ready), 32'(!busy));
      chk("we_eq_done", 32'(rf_we), 32'(done));
      if (!busy) chk("idle_addr", 32'(rf_addr), 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=done expected=no_done addr=%0d", rf_addr);
        end else begin
          e = q.pop_front();
          chk("wb_we", 32'(rf_we), 1);
          chk("wb_addr", 32'(rf_addr), 32'(e.addr));
          chk("wb_data", 32'(rf_wdata), 32'(e.data));
          chk("wb_carry", 32'(carry_flag), 32'(e.carry));
          chk("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
          if (e.is_alu) begin
            chk("alu_a", 32'(alu_a), 32'(e.a));
            chk("alu_b", 32'(alu_b), 32'(e.b));
            chk("alu_sel", 32'(alu_sel), 32'(e.op));
          end
        end
      end else begin
        chk("nowb_wdata", 32'(rf_wdata), 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    rf_clear = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_carry", 32'(carry_flag), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_sel", 32'(alu_sel), 0);

    // Directed sequence
    issue(mk(6, 0, 0, 5), 1);
    issue(mk(6, 1, 0, 3), 1);
    issue(mk(0, 0, 1, 0), 1);
    wait_idle();
    chk("add_r0", 32'(rf_mem[0]), 8);
    chk("add_carry0", 32'(carry_flag), 0);
    issue(mk(6, 2, 0, 15), 1);
    issue(mk(6, 3, 0, 1), 1);
    issue(mk(0, 2, 3, 0), 1);
    wait_idle();
    chk("ovf_r2", 32'(rf_mem[2]), 0);
    chk("ovf_carry", 32'(carry_flag), 1);
    issue(mk(4, 1, 1, 0), 1);
    wait_idle();
    chk("xor_r1", 32'(rf_mem[1]), 0);
    chk("xor_keeps_carry", 32'(carry_flag), 1);
    issue(mk(0, 3, 3, 0), 1);
    wait_idle();
    chk("chain_r3", 32'(rf_mem[3]), CHAIN ? 3 : 2);

    // Randomized instructions with random gaps
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 15)), 1);
    end
    wait_idle();

    // Abort an ADD in EXEC with reset
    issue(mk(6, 0, 0, 9), 1);
    issue(mk(6, 3, 0, 4), 1);
    wait_idle();
    issue(mk(0, 0, 3, 0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_carry = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(rf_we), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_carry", 32'(carry_flag), 0);
    chk("abort_alu_sel", 32'(alu_sel), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_r0", 32'(rf_mem[0]), 9);

    // A few more after reset
    for (int i = 0; i < 40; i++) begin
      issue(mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 15)), 1);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("final_r%0d", i), 32'(rf_mem[i]), 32'(m_regs[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control FSM that drives the 4-bit datapath: 4x4-bit synchronous register file, 8-function ALU (3-bit selector, carry in/out), and the write-data path.
- Accepts one instruction at a time over a valid/ready handshake.
- Sequences each instruction as register reads, operand latch, ALU execute and register write-back, then pulses done.
- Sits between the instruction source (testbench or future fetch unit) and the datapath.

Parameters:
- DW, 4, datapath word width (register file, ALU operands, immediate)
- AW, 2, register address width (4 registers)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  12  [11:9] opcode, [8:7] dst, [6:5] src, [4] unused, [3:0] imm
- rf_addr  out  AW  register file address
- rf_we  out  1  register file write enable
- rf_wdata  out  DW  register file write data
- rf_rdata  in  DW  register file read data (registered: value of rf_addr one cycle after it is presented)
- alu_a  out  DW  ALU operand A (registered)
- alu_b  out  DW  ALU operand B (registered)
- alu_sel  out  3  ALU selector (registered)
- alu_cin  out  1  ALU carry in
- alu_result  in  DW  ALU result
- alu_cout  in  1  ALU carry out
- carry_flag  out  1  stored carry
- done  out  1  one-cycle pulse in the write-back cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs and the internal instruction, operand and result registers clear to 0: alu_a, alu_b, alu_sel, carry_flag.
  - rf_we=0, done=0, busy=0, instr_ready=1 once rst_n=1.
  - Reset mid-instruction aborts it with no register write; a write asserted in the reset cycle is suppressed.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 111 NOT A, 110 LDI (dst <= imm).
- Operand roles: dst is both operand A and destination; src is operand B.
- State IDLE:
  - instr_ready=1, rf_we=0.
  - On instr_valid & instr_ready at a clock edge, latch instr.
  - Next state is WB if opcode=110, otherwise RD_A.
- State RD_A: rf_addr=dst, rf_we=0 → RD_B.
- State RD_B: rf_addr=src; at end of cycle alu_a <= rf_rdata (dst value) → LAT_B.
- State LAT_B: rf_addr=src; at end of cycle alu_b <= rf_rdata, alu_sel <= opcode → EXEC.
- State EXEC:
  - ALU settles combinationally; at end of cycle result register <= alu_result.
  - For ADD/SUB only: carry_flag <= alu_cout. Other ops leave carry_flag unchanged.
  - → WB.
- State WB:
  - rf_addr=dst, rf_we=1, done=1.
  - rf_wdata = imm for LDI, result register otherwise.
  - → IDLE.
- Latency:
  - ALU op: accept edge E; done high in the 5th cycle after E; register updated at end of that cycle.
  - LDI: done high in the 1st cycle after E.
  - Back-to-back instructions are accepted in the cycle after WB. instr_ready is low whenever busy is high.
- rf_wdata: 0 outside WB. rf_addr: 0 in IDLE.
- dst==src is legal: both operands equal the same register value.
- Arithmetic: widths are DW; the ALU carry_out is the only overflow indication. The sequencer performs no arithmetic itself.
- alu_cin: see Optional Feature.

Optional Feature:
- Macro: DATAPATH_CARRY_CHAIN_EN.
- Defined: alu_cin = carry_flag during EXEC, enabling multi-word add/sub chains. alu_cin is 0 in all other states.
- Undefined: alu_cin is tied 0. carry_flag is still updated and visible.

Test Plan:
- Reset → instr_ready=1, busy=0, rf_we=0, carry_flag=0, alu_a/alu_b/alu_sel=0.
- LDI r0,5 then LDI r1,3 → each done 1 cycle after accept; writes r0=5, r1=3 (rf_we=1, rf_addr=0/1, rf_wdata=5/3).
- ADD r0,r1 (r0=5, r1=3) → alu_a=5, alu_b=3, alu_sel=000; done 5 cycles after accept; write r0=8; carry_flag=0.
- LDI r2,F; LDI r3,1; ADD r2,r3 → r2=0, carry_flag=1. Then ADD r3,r3: with macro r3=3, without macro r3=2.
- XOR r1,r1 (r1=3) → r1=0; carry_flag unchanged from the previous value.
- Issue ADD, deassert rst_n in EXEC → no rf_we pulse, state IDLE, done never asserted, target register unchanged.
